// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit and its ALU:
// opcodes, functs, aluop codes, FSM states and datapath mux selects.
`timescale 1ns/1ps
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [3:0] ALUOP_ADD = 4'b0000;
    localparam logic [3:0] ALUOP_SUB = 4'b0001;
    localparam logic [3:0] ALUOP_OR  = 4'b0010;
    localparam logic [3:0] ALUOP_EQ  = 4'b0011;
    localparam logic [3:0] ALUOP_SLL = 4'b0100;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_REG    = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [4:0] LUI_SHAMT = 5'd16;

    typedef struct packed {
        logic addu;
        logic subu;
        logic sll;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } instrClass_t;

    function automatic logic isRType(input instrClass_t cls);
        return cls.addu | cls.subu | cls.sll;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to a one-hot class
// vector, with illegal raised when nothing matches.
`timescale 1ns/1ps
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    output instrClass_t o_class,
    output logic        o_illegal
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: o_class.addu = 1'b1;
                    FN_SUBU: o_class.subu = 1'b1;
                    FN_SLL:  o_class.sll  = 1'b1;
                    FN_JR:   o_class.jr   = 1'b1;
                    default: ;
                endcase
            end
            OP_J:    o_class.j   = 1'b1;
            OP_JAL:  o_class.jal = 1'b1;
            OP_BEQ:  o_class.beq = 1'b1;
            OP_ORI:  o_class.ori = 1'b1;
            OP_LUI:  o_class.lui = 1'b1;
            OP_LW:   o_class.lw  = 1'b1;
            OP_SW:   o_class.sw  = 1'b1;
            default: ;
        endcase
    end

    assign o_illegal = ~|o_class;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) driving a shared ALU.
// Define MC_CTRL_PERF_EN to build the cycle/instruction performance counters.
`timescale 1ns/1ps
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        alu_eq,
    input  logic        dm_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        dm_re,
    output logic        dm_we,
    output logic [1:0]  npc_sel,
    output logic [1:0]  reg_dst_sel,
    output logic [1:0]  wd_sel,
    output logic        alu_b_sel,
    output logic        ext_op,
    output logic [3:0]  aluop,
    output logic [4:0]  shamt,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    state_e      r_state;
    state_e      w_nextState;
    instrClass_t w_class;
    logic        w_illegal;
    logic        w_unusedInstr;

    assign w_unusedInstr = ^instr[25:11];

    mc_decode u_decode (
        .i_opcode  (instr[31:26]),
        .i_funct   (instr[5:0]),
        .o_class   (w_class),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_FETCH;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = ST_FETCH;
        case (r_state)
            ST_FETCH:  w_nextState = ST_DECODE;
            ST_DECODE: begin
                if (w_class.j || w_class.jal || w_class.jr || w_illegal)
                    w_nextState = ST_FETCH;
                else
                    w_nextState = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_class.lw || w_class.sw) w_nextState = ST_MEM;
                else if (w_class.beq)         w_nextState = ST_FETCH;
                else                          w_nextState = ST_WB;
            end
            ST_MEM: begin
                if (!dm_ready)      w_nextState = ST_MEM;
                else if (w_class.lw) w_nextState = ST_WB;
                else                w_nextState = ST_FETCH;
            end
            ST_WB:   w_nextState = ST_FETCH;
            default: w_nextState = ST_FETCH;
        endcase
    end

    // Reset gates every write enable combinationally so an abort mid-access takes effect at once.
    always_comb begin
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        reg_we      = 1'b0;
        dm_re       = 1'b0;
        dm_we       = 1'b0;
        npc_sel     = NPC_PC4;
        reg_dst_sel = REGDST_RT;
        wd_sel      = WD_ALU;
        alu_b_sel   = 1'b0;
        ext_op      = 1'b0;
        aluop       = ALUOP_ADD;
        shamt       = 5'd0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                ir_we = 1'b1;
                pc_we = 1'b1;
            end
            ST_DECODE: begin
                if (w_class.j || w_class.jal) begin
                    pc_we      = 1'b1;
                    npc_sel    = NPC_JUMP;
                    instr_done = 1'b1;
                end
                if (w_class.jal) begin
                    reg_we      = 1'b1;
                    reg_dst_sel = REGDST_RA;
                    wd_sel      = WD_PC;
                end
                if (w_class.jr) begin
                    pc_we      = 1'b1;
                    npc_sel    = NPC_REG;
                    instr_done = 1'b1;
                end
                if (w_illegal) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            ST_EXEC: begin
                if (w_class.subu) aluop = ALUOP_SUB;
                if (w_class.sll) begin
                    aluop = ALUOP_SLL;
                    shamt = instr[10:6];
                end
                if (w_class.ori) begin
                    aluop     = ALUOP_OR;
                    alu_b_sel = 1'b1;
                end
                if (w_class.lui) begin
                    aluop     = ALUOP_SLL;
                    alu_b_sel = 1'b1;
                    shamt     = LUI_SHAMT;
                end
                if (w_class.lw || w_class.sw) begin
                    alu_b_sel = 1'b1;
                    ext_op    = 1'b1;
                end
                if (w_class.beq) begin
                    aluop      = ALUOP_EQ;
                    pc_we      = alu_eq;
                    npc_sel    = NPC_BRANCH;
                    instr_done = 1'b1;
                end
            end
            ST_MEM: begin
                dm_re      = w_class.lw;
                dm_we      = w_class.sw;
                instr_done = w_class.sw & dm_ready;
            end
            ST_WB: begin
                reg_we      = 1'b1;
                reg_dst_sel = isRType(w_class) ? REGDST_RD : REGDST_RT;
                wd_sel      = w_class.lw ? WD_DM : WD_ALU;
                instr_done  = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            dm_re      = 1'b0;
            dm_we      = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = r_state;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] r_cycleCnt;
    logic [31:0] r_instrCnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycleCnt <= 32'd0;
            r_instrCnt <= 32'd0;
        end else begin
            r_cycleCnt <= r_cycleCnt + 32'd1;
            if (instr_done) r_instrCnt <= r_instrCnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycleCnt;
    assign instr_cnt = r_instrCnt;
`else
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: walks each instruction class
// cycle by cycle and compares state, enables and mux selects to hand values.
`timescale 1ns/1ps
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        alu_eq;
    logic        dm_ready;
    logic        pc_we, ir_we, reg_we, dm_re, dm_we;
    logic [1:0]  npc_sel, reg_dst_sel, wd_sel;
    logic        alu_b_sel, ext_op;
    logic [3:0]  aluop;
    logic [4:0]  shamt;
    logic [2:0]  state;
    logic        instr_done, illegal;
    logic [31:0] cycle_cnt, instr_cnt;

    int checks = 0;
    int errors = 0;

    // Enable vector order: pc_we, ir_we, reg_we, dm_re, dm_we, instr_done, illegal
    localparam logic [6:0] EN_NONE   = 7'b0000000;
    localparam logic [6:0] EN_FETCH  = 7'b1100000;
    localparam logic [6:0] EN_WBDONE = 7'b0010010;
    localparam logic [6:0] EN_DMRE   = 7'b0001000;
    localparam logic [6:0] EN_DMWE   = 7'b0000100;
    localparam logic [6:0] EN_BR     = 7'b1000010;
    localparam logic [6:0] EN_DONE   = 7'b0000010;
    localparam logic [6:0] EN_JAL    = 7'b1010010;
    localparam logic [6:0] EN_ILL    = 7'b0000011;

    localparam logic [31:0] I_ADDU = 32'h00221821;
    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_LUI  = 32'h3C011234;
    localparam logic [31:0] I_JAL  = 32'h0C100003;
    localparam logic [31:0] I_BAD  = 32'hFC000000;
    localparam logic [31:0] I_JR   = 32'h03E00008;
    localparam logic [31:0] I_ORI  = 32'h3441FFFF;
    localparam logic [31:0] I_SLL  = 32'h00011140;
    localparam logic [31:0] I_SW   = 32'hAC220008;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .alu_eq      (alu_eq),
        .dm_ready    (dm_ready),
        .pc_we       (pc_we),
        .ir_we       (ir_we),
        .reg_we      (reg_we),
        .dm_re       (dm_re),
        .dm_we       (dm_we),
        .npc_sel     (npc_sel),
        .reg_dst_sel (reg_dst_sel),
        .wd_sel      (wd_sel),
        .alu_b_sel   (alu_b_sel),
        .ext_op      (ext_op),
        .aluop       (aluop),
        .shamt       (shamt),
        .state       (state),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCycle(input string tag, input logic [2:0] expState, input logic [6:0] expEn);
        checkOutput({tag, ".state"}, {29'd0, state}, {29'd0, expState});
        checkOutput({tag, ".en"},
                    {25'd0, pc_we, ir_we, reg_we, dm_re, dm_we, instr_done, illegal},
                    {25'd0, expEn});
    endtask

    task automatic applyStimulus(input logic [31:0] i, input logic eq, input logic rdy);
        instr    = i;
        alu_eq   = eq;
        dm_ready = rdy;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        instr    = 32'd0;
        alu_eq   = 1'b0;
        dm_ready = 1'b1;
        stepClock();
        stepClock();
        checkCycle("rst", 3'd0, EN_NONE);
        checkOutput("rst.cycle_cnt", cycle_cnt, 32'd0);
        checkOutput("rst.instr_cnt", instr_cnt, 32'd0);
        reset = 1'b1;

        // addu: F D E W
        applyStimulus(I_ADDU, 1'b0, 1'b1);
        checkCycle("addu.F", 3'd0, EN_FETCH);
        checkOutput("addu.F.npc", {30'd0, npc_sel}, 32'd0);
        stepClock(); checkCycle("addu.D", 3'd1, EN_NONE);
        stepClock(); checkCycle("addu.E", 3'd2, EN_NONE);
        checkOutput("addu.E.aluop", {28'd0, aluop}, 32'd0);
        checkOutput("addu.E.bsel", {31'd0, alu_b_sel}, 32'd0);
        stepClock(); checkCycle("addu.W", 3'd4, EN_WBDONE);
        checkOutput("addu.W.dst", {30'd0, reg_dst_sel}, 32'd1);
        checkOutput("addu.W.wd", {30'd0, wd_sel}, 32'd0);
        stepClock();

        // lw with two not-ready cycles in MEM
        applyStimulus(I_LW, 1'b0, 1'b1);
        checkCycle("lw.F", 3'd0, EN_FETCH);
`ifdef MC_CTRL_PERF_EN
        checkOutput("perf.cycle4", cycle_cnt, 32'd4);
        checkOutput("perf.instr1", instr_cnt, 32'd1);
`else
        checkOutput("perf.cycle_off", cycle_cnt, 32'd0);
        checkOutput("perf.instr_off", instr_cnt, 32'd0);
`endif
        stepClock(); checkCycle("lw.D", 3'd1, EN_NONE);
        stepClock(); checkCycle("lw.E", 3'd2, EN_NONE);
        checkOutput("lw.E.aluop", {28'd0, aluop}, 32'd0);
        checkOutput("lw.E.bsel", {31'd0, alu_b_sel}, 32'd1);
        checkOutput("lw.E.ext", {31'd0, ext_op}, 32'd1);
        applyStimulus(I_LW, 1'b0, 1'b0);
        stepClock(); checkCycle("lw.M1", 3'd3, EN_DMRE);
        stepClock(); checkCycle("lw.M2", 3'd3, EN_DMRE);
        applyStimulus(I_LW, 1'b0, 1'b1);
        checkCycle("lw.M3", 3'd3, EN_DMRE);
        stepClock(); checkCycle("lw.W", 3'd4, EN_WBDONE);
        checkOutput("lw.W.wd", {30'd0, wd_sel}, 32'd1);
        checkOutput("lw.W.dst", {30'd0, reg_dst_sel}, 32'd0);
        stepClock();

        // beq taken
        applyStimulus(I_BEQ, 1'b1, 1'b1);
        checkCycle("beq1.F", 3'd0, EN_FETCH);
        stepClock(); checkCycle("beq1.D", 3'd1, EN_NONE);
        stepClock(); checkCycle("beq1.E", 3'd2, EN_BR);
        checkOutput("beq1.E.npc", {30'd0, npc_sel}, 32'd1);
        checkOutput("beq1.E.aluop", {28'd0, aluop}, 32'd3);
        checkOutput("beq1.E.bsel", {31'd0, alu_b_sel}, 32'd0);
        stepClock();

        // beq not taken
        applyStimulus(I_BEQ, 1'b0, 1'b1);
        checkCycle("beq0.F", 3'd0, EN_FETCH);
        stepClock(); checkCycle("beq0.D", 3'd1, EN_NONE);
        stepClock(); checkCycle("beq0.E", 3'd2, EN_DONE);
        stepClock();

        // lui
        applyStimulus(I_LUI, 1'b0, 1'b1);
        checkCycle("lui.F", 3'd0, EN_FETCH);
        stepClock(); checkCycle("lui.D", 3'd1, EN_NONE);
        stepClock(); checkCycle("lui.E", 3'd2, EN_NONE);
        checkOutput("lui.E.aluop", {28'd0, aluop}, 32'd4);
        checkOutput("lui.E.shamt", {27'd0, shamt}, 32'd16);
        checkOutput("lui.E.bsel", {31'd0, alu_b_sel}, 32'd1);
        checkOutput("lui.E.ext", {31'd0, ext_op}, 32'd0);
        stepClock(); checkCycle("lui.W", 3'd4, EN_WBDONE);
        checkOutput("lui.W.dst", {30'd0, reg_dst_sel}, 32'd0);
        stepClock();

        // jal
        applyStimulus(I_JAL, 1'b0, 1'b1);
        checkCycle("jal.F", 3'd0, EN_FETCH);
        stepClock(); checkCycle("jal.D", 3'd1, EN_JAL);
        checkOutput("jal.D.npc", {30'd0, npc_sel}, 32'd2);
        checkOutput("jal.D.dst", {30'd0, reg_dst_sel}, 32'd2);
        checkOutput("jal.D.wd", {30'd0, wd_sel}, 32'd2);
        stepClock(); checkCycle("jal.next", 3'd0, EN_FETCH);

        // unknown opcode
        applyStimulus(I_BAD, 1'b0, 1'b1);
        stepClock(); checkCycle("bad.D", 3'd1, EN_ILL);
        stepClock(); checkCycle("bad.next", 3'd0, EN_FETCH);

        // jr
        applyStimulus(I_JR, 1'b0, 1'b1);
        stepClock(); checkCycle("jr.D", 3'd1, EN_BR);
        checkOutput("jr.D.npc", {30'd0, npc_sel}, 32'd3);
        stepClock(); checkCycle("jr.next", 3'd0, EN_FETCH);

        // ori
        applyStimulus(I_ORI, 1'b0, 1'b1);
        stepClock(); stepClock(); checkCycle("ori.E", 3'd2, EN_NONE);
        checkOutput("ori.E.aluop", {28'd0, aluop}, 32'd2);
        checkOutput("ori.E.bsel", {31'd0, alu_b_sel}, 32'd1);
        checkOutput("ori.E.ext", {31'd0, ext_op}, 32'd0);
        stepClock(); checkCycle("ori.W", 3'd4, EN_WBDONE);
        checkOutput("ori.W.dst", {30'd0, reg_dst_sel}, 32'd0);
        stepClock();

        // sll $2,$1,5
        applyStimulus(I_SLL, 1'b0, 1'b1);
        stepClock(); stepClock(); checkCycle("sll.E", 3'd2, EN_NONE);
        checkOutput("sll.E.aluop", {28'd0, aluop}, 32'd4);
        checkOutput("sll.E.shamt", {27'd0, shamt}, 32'd5);
        checkOutput("sll.E.bsel", {31'd0, alu_b_sel}, 32'd0);
        stepClock(); checkCycle("sll.W", 3'd4, EN_WBDONE);
        checkOutput("sll.W.dst", {30'd0, reg_dst_sel}, 32'd1);
        stepClock();

        // sw aborted by reset while waiting in MEM
        applyStimulus(I_SW, 1'b0, 1'b1);
        checkCycle("sw.F", 3'd0, EN_FETCH);
        stepClock(); checkCycle("sw.D", 3'd1, EN_NONE);
        stepClock(); checkCycle("sw.E", 3'd2, EN_NONE);
        checkOutput("sw.E.ext", {31'd0, ext_op}, 32'd1);
        applyStimulus(I_SW, 1'b0, 1'b0);
        stepClock(); checkCycle("sw.M", 3'd3, EN_DMWE);
        reset = 1'b0;
        #1;
        checkCycle("sw.rstNow", 3'd3, EN_NONE);
        stepClock(); checkCycle("sw.rstEdge", 3'd0, EN_NONE);
        checkOutput("sw.rst.cycle", cycle_cnt, 32'd0);
        checkOutput("sw.rst.instr", instr_cnt, 32'd0);
        reset = 1'b1;
        #1;
        checkCycle("sw.release", 3'd0, EN_FETCH);
        stepClock(); checkCycle("sw.after", 3'd1, EN_NONE);
`ifdef MC_CTRL_PERF_EN
        checkOutput("perf.restart", cycle_cnt, 32'd1);
`else
        checkOutput("perf.restart_off", cycle_cnt, 32'd0);
`endif
        checkOutput("perf.instr0", instr_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
